// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - RV32IM instruction fetch with IF/ID register, redirect, halt and fault handling
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int          MEM_WORDS      = 256,
  parameter bit          HALT_ON_SYSTEM = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  input  logic        id_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        halted,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_HALT  = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  localparam logic [31:0] MEM_WORDS_W = 32'(MEM_WORDS);
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic [1:0]  fault_cause_q, fault_cause_d;
  logic [31:0] fetch_count_q, fetch_count_d;

  logic advance;
  logic take;
  logic redirect_accept;
  logic pc_out_of_range;
  logic is_system;

  assign advance         = !if_valid_q || id_ready;
  assign take            = if_valid_q && id_ready;
  // FAULT ignores redirects, so only RUN/HALT redirects flush the held instruction
  assign redirect_accept = redirect_valid && (state_q != S_FAULT);
  assign pc_out_of_range = {2'b00, pc_q[31:2]} >= MEM_WORDS_W;
  assign is_system       = (imem_instr[6:0] == 7'h73) && (imem_instr[14:12] == 3'b000);

  // Next-state: redirect beats normal fetch; a flushed instruction is never counted
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    if_valid_d    = if_valid_q;
    if_pc_d       = if_pc_q;
    if_instr_d    = if_instr_q;
    fault_cause_d = fault_cause_q;
    fetch_count_d = fetch_count_q + ((take && !redirect_accept) ? 32'd1 : 32'd0);

    case (state_q)
      S_RUN, S_HALT: begin
        if (redirect_valid) begin
          if_valid_d = 1'b0;
          if (redirect_pc[1:0] != 2'b00) begin
            state_d       = S_FAULT;
            fault_cause_d = 2'b01;
          end else begin
            pc_d    = redirect_pc;
            state_d = S_RUN;
          end
        end else if (state_q == S_RUN) begin
          if (advance) begin
            if (pc_out_of_range) begin
              state_d       = S_FAULT;
              fault_cause_d = 2'b10;
              if_valid_d    = 1'b0;
            end else begin
              if_pc_d    = pc_q;
              if_instr_d = imem_instr;
              if_valid_d = 1'b1;
              pc_d       = pc_q + 32'd4;
              if (HALT_ON_SYSTEM && is_system) begin
                state_d = S_HALT;
              end
            end
          end
        end else if (take) begin
          // HALT: drain the pending instruction, capture nothing new
          if_valid_d = 1'b0;
        end
      end
      default: begin
        if_valid_d = 1'b0;
      end
    endcase
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_RUN;
      pc_q          <= RESET_PC;
      if_valid_q    <= 1'b0;
      if_pc_q       <= 32'h0000_0000;
      if_instr_q    <= NOP_INSTR;
      fault_cause_q <= 2'b00;
      fetch_count_q <= 32'h0000_0000;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      if_valid_q    <= if_valid_d;
      if_pc_q       <= if_pc_d;
      if_instr_q    <= if_instr_d;
      fault_cause_q <= fault_cause_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign imem_addr   = pc_q;
  assign if_valid    = if_valid_q;
  assign if_pc       = if_pc_q;
  assign if_instr    = if_instr_q;
  assign halted      = (state_q == S_HALT);
  assign fault       = (state_q == S_FAULT);
  assign fault_cause = fault_cause_q;
  assign fetch_count = fetch_count_q;

endmodule
